shift_seq_ctrl: RTL and testbench

- Multi-cycle shift sequencer for the ALU shift path.
- Accepts one shift request at a time over a valid/ready handshake.
- Applies the shift in chunks of at most STEP bits per clock, then presents the result over a second valid/ready handshake.
- Lets the datapath trade a full barrel shifter for a small per-step shifter; the CPU control unit drives it as a multi-cycle ALU op.

---
 rtl/shift_seq_pkg.sv | 23 ++
 rtl/shift_step.sv | 31 +++
 rtl/shift_seq_ctrl.sv | 109 ++++++++++
 tb/tb_shift_seq_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared op codes, FSM encoding and op-legality check for the shift sequencer.
// Build option: SHIFT_SEQ_ROTATE_EN makes ROL/ROR legal ops.
package shift_seq_pkg;

    localparam logic [2:0] OP_SHL  = 3'd0;
    localparam logic [2:0] OP_SHR  = 3'd1;
    localparam logic [2:0] OP_SHRA = 3'd2;
    localparam logic [2:0] OP_ROL  = 3'd3;
    localparam logic [2:0] OP_ROR  = 3'd4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic op_legal(input logic [2:0] op);
`ifdef SHIFT_SEQ_ROTATE_EN
        return (op <= OP_ROR);
`else
        return (op <= OP_SHRA);
`endif
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves value by k (k <= STEP) bits per op.
// Rotate paths exist only when SHIFT_SEQ_ROTATE_EN is defined.
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int KW    = $clog2(STEP) + 1
) (
    input  logic [WIDTH-1:0] value,
    input  logic [2:0]       op,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = value;
        case (op)
            OP_SHL:  result = value << k;
            OP_SHR:  result = value >> k;
            OP_SHRA: result = $signed(value) >>> k;
`ifdef SHIFT_SEQ_ROTATE_EN
            // a right shift by WIDTH yields 0, so k=0 degenerates cleanly
            OP_ROL:  result = (value << k) | (value >> (WIDTH - int'(k)));
            OP_ROR:  result = (value >> k) | (value << (WIDTH - int'(k)));
`endif
            default: result = value;
        endcase
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: accepts a request, shifts STEP bits per clock, hands back the result.
// Build option: SHIFT_SEQ_ROTATE_EN enables ROL/ROR.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_operand,
    input  logic [AMT_W-1:0] in_amount,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_err,
    output logic             busy
);

    localparam int KW = $clog2(STEP) + 1;

    logic [1:0]       state;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] res_q;
    logic [2:0]       op_q;
    logic [AMT_W-1:0] rem;
    logic             err_q;

    logic [KW-1:0]    k;
    logic [AMT_W-1:0] rem_nxt;
    logic [WIDTH-1:0] step_val;
    logic             accept;
    logic             legal;

    assign accept = in_valid && (state == ST_IDLE);
    assign legal  = op_legal(in_op);

    // k = min(rem, STEP); the narrowing cast only happens when rem < STEP
    always_comb begin
        k = KW'(STEP);
        if (int'(rem) < STEP)
            k = KW'(rem);
    end

    assign rem_nxt = rem - AMT_W'(k);

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .KW    (KW)
    ) u_step (
        .value  (work),
        .op     (op_q),
        .k      (k),
        .result (step_val)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= ST_IDLE;
            work  <= '0;
            res_q <= '0;
            op_q  <= '0;
            rem   <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        work  <= in_operand;
                        op_q  <= in_op;
                        rem   <= in_amount;
                        err_q <= !legal;
                        if (legal && (in_amount != '0)) begin
                            state <= ST_SHIFT;
                        end else begin
                            res_q <= in_operand;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    work <= step_val;
                    rem  <= rem_nxt;
                    if (rem_nxt == '0) begin
                        res_q <= step_val;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready   = (state == ST_IDLE);
    assign out_valid  = (state == ST_DONE);
    assign busy       = (state != ST_IDLE);
    assign out_result = res_q;
    assign out_err    = err_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: one STEP=1 and one STEP=4 instance, hand-computed vectors.
module tb_shift_seq_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic [2:0]  op;
    logic [31:0] opnd;
    logic [4:0]  amt;
    logic        out_ready;

    logic        iv0, ir0, ov0, oe0, bz0;
    logic        iv1, ir1, ov1, oe1, bz1;
    logic [31:0] res0, res1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shift_seq_ctrl #(.WIDTH(32), .AMT_W(5), .STEP(1)) dut1 (
        .clk(clk), .clr(clr), .in_valid(iv0), .in_ready(ir0), .in_op(op),
        .in_operand(opnd), .in_amount(amt), .out_valid(ov0), .out_ready(out_ready),
        .out_result(res0), .out_err(oe0), .busy(bz0)
    );

    shift_seq_ctrl #(.WIDTH(32), .AMT_W(5), .STEP(4)) dut4 (
        .clk(clk), .clr(clr), .in_valid(iv1), .in_ready(ir1), .in_op(op),
        .in_operand(opnd), .in_amount(amt), .out_valid(ov1), .out_ready(out_ready),
        .out_result(res1), .out_err(oe1), .busy(bz1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] g_res(input int s);
        return s ? res1 : res0;
    endfunction
    function automatic logic g_ov(input int s);
        return s ? ov1 : ov0;
    endfunction
    function automatic logic g_ir(input int s);
        return s ? ir1 : ir0;
    endfunction
    function automatic logic g_oe(input int s);
        return s ? oe1 : oe0;
    endfunction
    function automatic logic g_bz(input int s);
        return s ? bz1 : bz0;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one request on instance s (0: STEP=1, 1: STEP=4) and check latency, result, err, return to IDLE.
    task automatic run(input string tag, input int s, input logic [2:0] o, input logic [31:0] v,
                       input logic [4:0] a, input logic [31:0] exp_res, input logic exp_err,
                       input int exp_lat);
        int  lat;
        logic rdy_bad;
        chk({tag, ".in_ready_pre"}, 32'(g_ir(s)), 32'd1);
        op = o; opnd = v; amt = a;
        if (s == 0) iv0 = 1'b1; else iv1 = 1'b1;
        tick();
        iv0 = 1'b0; iv1 = 1'b0;
        op = 3'd0; opnd = 32'h5A5A_A5A5; amt = 5'd17;
        lat = 0;
        rdy_bad = 1'b0;
        while (!g_ov(s) && lat < 100) begin
            if (g_ir(s) || !g_bz(s)) rdy_bad = 1'b1;
            tick();
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".ready_low"}, 32'(rdy_bad | g_ir(s)), 32'd0);
        chk({tag, ".result"}, g_res(s), exp_res);
        chk({tag, ".err"}, 32'(g_oe(s)), 32'(exp_err));
        tick();
        chk({tag, ".idle_valid"}, 32'(g_ov(s)), 32'd0);
        chk({tag, ".idle_result"}, g_res(s), exp_res);
    endtask

    initial begin
        logic        stab_bad;
        clr = 1'b1; iv0 = 1'b0; iv1 = 1'b0; op = 3'd0; opnd = '0; amt = '0; out_ready = 1'b1;
        tick();
        tick();
        clr = 1'b0;
        chk("rst.in_ready", 32'(ir0), 32'd1);
        chk("rst.out_valid", 32'(ov0), 32'd0);
        chk("rst.out_result", res0, 32'd0);
        chk("rst.out_err", 32'(oe0), 32'd0);
        chk("rst.busy", 32'(bz0), 32'd0);

        run("shl31",   0, 3'd0, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 31);
        run("shra4",   1, 3'd2, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0, 1);
        run("shr6",    1, 3'd1, 32'h8000_0000, 5'd6,  32'h0200_0000, 1'b0, 2);
        run("shra31",  1, 3'd2, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 8);
        run("shl7s4",  1, 3'd0, 32'h0000_0001, 5'd7,  32'h0000_0080, 1'b0, 2);
        run("shr5",    0, 3'd1, 32'hF000_0000, 5'd5,  32'h0780_0000, 1'b0, 5);

`ifdef SHIFT_SEQ_ROTATE_EN
        run("rol1",    0, 3'd3, 32'h8000_0001, 5'd1,  32'h0000_0003, 1'b0, 1);
        run("ror4",    1, 3'd4, 32'h0000_0001, 5'd4,  32'h1000_0000, 1'b0, 1);
`else
        run("rol_off", 0, 3'd3, 32'h8000_0001, 5'd1,  32'h8000_0001, 1'b1, 0);
        run("ror_off", 1, 3'd4, 32'h0000_0001, 5'd4,  32'h0000_0001, 1'b1, 0);
`endif
        run("ill7",    0, 3'd7, 32'h1234_5678, 5'd3,  32'h1234_5678, 1'b1, 0);
        run("legal",   0, 3'd0, 32'h0000_000F, 5'd4,  32'h0000_00F0, 1'b0, 4);

        // zero amount with the consumer stalled; extra requests must be ignored
        out_ready = 1'b0;
        op = 3'd0; opnd = 32'hDEAD_BEEF; amt = 5'd0; iv0 = 1'b1;
        tick();
        chk("hold.valid0", 32'(ov0), 32'd1);
        chk("hold.result0", res0, 32'hDEAD_BEEF);
        op = 3'd1; opnd = 32'h0000_1111; amt = 5'd3;
        stab_bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!ov0 || ir0 || res0 !== 32'hDEAD_BEEF || oe0) stab_bad = 1'b1;
        end
        chk("hold.stable", 32'(stab_bad), 32'd0);
        iv0 = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("hold.release_valid", 32'(ov0), 32'd0);
        chk("hold.release_ready", 32'(ir0), 32'd1);
        chk("hold.release_result", res0, 32'hDEAD_BEEF);

        // clr in the middle of a long shift
        op = 3'd0; opnd = 32'h0000_0001; amt = 5'd20; iv0 = 1'b1;
        tick();
        iv0 = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("clr.busy_before", 32'(bz0), 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr.valid", 32'(ov0), 32'd0);
        chk("clr.result", res0, 32'd0);
        chk("clr.ready", 32'(ir0), 32'd1);
        chk("clr.busy", 32'(bz0), 32'd0);
        tick();
        chk("clr.still_idle", 32'(ov0), 32'd0);
        run("post_clr", 0, 3'd0, 32'h0000_0003, 5'd2, 32'h0000_000C, 1'b0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
